// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - REG_WIDTH / ALU_OPCODE_WIDTH : default operand and opcode widths
//   - ALU_* opcode constants (13..15 are undefined)
//   - state_e : top-level control states
//   - is_iterative() : true for the multi-cycle mul/div opcodes
package alu_seq_pkg;

  localparam int REG_WIDTH        = 32;
  localparam int ALU_OPCODE_WIDTH = 4;

  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_SLTU = 4'd9;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_MUL  = 4'd10;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_DIVU = 4'd11;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_REMU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [ALU_OPCODE_WIDTH-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply / unsigned divide datapath.
// One bit per cycle: shift-add multiply, restoring division.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load operands and begin (ignored unless idle upstream)
//   op_mul, op_rem    select MUL, or REMU (else DIVU) when start is high
//   a, b              operands (a = multiplier/dividend, b = multiplicand/divisor)
//   done              high in the cycle whose rising edge performs the last step
//   result            final value, valid while done is high (includes last step)
//   dbz               divisor was zero for the running divide/remainder
module alu_muldiv_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_mul,
  input  logic             op_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator or partial remainder
  logic [WIDTH-1:0] a_q, a_d;       // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0] b_q, b_d;       // multiplicand (shifts left) or divisor
  logic             mul_q, mul_d;
  logic             rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] step_acc, step_a, step_b;

  // One iteration of whichever operation is running.
  always_comb begin
    mul_acc = acc_q + (a_q[0] ? b_q : '0);

    // Bring in the next dividend bit; a borrow out of the extra top bit
    // means the divisor does not fit and the remainder is restored.
    // A zero divisor always fits, which yields all-ones and the dividend.
    rem_sh = {acc_q, a_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    if (trial[WIDTH]) begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {a_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {a_q[WIDTH-2:0], 1'b1};
    end

    if (mul_q) begin
      step_acc = mul_acc;
      step_a   = a_q >> 1;
      step_b   = b_q << 1;
    end else begin
      step_acc = rem_next;
      step_a   = quo_next;
      step_b   = b_q;
    end
  end

  assign done   = busy_q && (cnt_q == '0);
  assign result = (mul_q || rem_q) ? step_acc : step_a;
  assign dbz    = dbz_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    mul_d  = mul_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
      acc_d  = '0;
      a_d    = a;
      b_d    = b;
      mul_d  = op_mul;
      rem_d  = op_rem;
      dbz_d  = !op_mul && (b == '0);
    end else if (busy_q) begin
      acc_d = step_acc;
      a_d   = step_a;
      b_d   = step_b;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mul_q  <= mul_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU.
// Single-cycle ops complete one edge after accept; MUL/DIVU/REMU iterate for
// WIDTH edges in alu_muldiv_seq. Results sit in one output register.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          issue handshake; src1, src2, opcode captured on accept
//   out_valid/out_ready        writeback handshake
//   result, zero, dbz, illegal registered result and flags
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int OPW   = ALU_OPCODE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             dbz,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             illegal_q, illegal_d;

  logic [ALU_OPCODE_WIDTH-1:0] op_lo;
  logic                        op_defined;
  logic                        iter_op;
  logic                        accept;
  logic                        md_start;
  logic                        md_done;
  logic [WIDTH-1:0]            md_result;
  logic                        md_dbz;
  logic [SHW-1:0]              shamt;
  logic [WIDTH-1:0]            sc_result;

  assign op_lo      = opcode[ALU_OPCODE_WIDTH-1:0];
  assign op_defined = (opcode <= OPW'(ALU_REMU));
  assign iter_op    = op_defined && is_iterative(op_lo);
  assign shamt      = src2[SHW-1:0];

  // Accept only when idle and the output register is free or draining now.
  assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && iter_op;

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op_mul (op_lo == ALU_MUL),
    .op_rem (op_lo == ALU_REMU),
    .a      (src1),
    .b      (src2),
    .done   (md_done),
    .result (md_result),
    .dbz    (md_dbz)
  );

  // Single-cycle datapath; undefined opcodes produce zero.
  always_comb begin
    sc_result = '0;
    case (op_lo)
      ALU_ADD:  sc_result = src1 + src2;
      ALU_SUB:  sc_result = src1 - src2;
      ALU_AND:  sc_result = src1 & src2;
      ALU_OR:   sc_result = src1 | src2;
      ALU_XOR:  sc_result = src1 ^ src2;
      ALU_SLL:  sc_result = src1 << shamt;
      ALU_SRL:  sc_result = src1 >> shamt;
      ALU_SRA:  sc_result = WIDTH'($signed(src1) >>> shamt);
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      default:  sc_result = '0;
    endcase
    if (!op_defined) begin
      sc_result = '0;
    end
  end

  // Control state and output register.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    illegal_d   = illegal_q;

    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_BUSY;
      ST_BUSY: if (md_done) state_d = ST_HOLD;
      ST_HOLD: if (out_valid_q && out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new single-cycle result overwrites whatever drains on the same edge.
    if (accept && !iter_op) begin
      out_valid_d = 1'b1;
      result_d    = sc_result;
      zero_d      = (sc_result == '0);
      dbz_d       = 1'b0;
      illegal_d   = !op_defined;
    end else if (md_done) begin
      out_valid_d = 1'b1;
      result_d    = md_result;
      zero_d      = (md_result == '0);
      dbz_d       = md_dbz;
      illegal_d   = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign dbz       = dbz_q;
  assign illegal   = illegal_q;

endmodule
